// File: rtl/decode_if.sv
// ============================================================================
// decode_if : fetch -> decode -> exec handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface decode_if;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_instr_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [3:0]  id_class_o;
  logic [4:0]  id_rd_o;
  logic [4:0]  id_rs1_o;
  logic [4:0]  id_rs2_o;
  logic [2:0]  id_funct3_o;
  logic        id_funct7b5_o;
  logic [31:0] id_imm_o;
  logic        id_illegal_o;

  // master: the surrounding pipeline (fetch producer + exec consumer)
  modport master (
    output fetch_valid_i, fetch_instr_i, id_ready_i,
    input  fetch_ready_o, id_valid_o, id_pc_o, id_class_o, id_rd_o, id_rs1_o,
           id_rs2_o, id_funct3_o, id_funct7b5_o, id_imm_o, id_illegal_o
  );

  modport slave (
    input  fetch_valid_i, fetch_instr_i, id_ready_i,
    output fetch_ready_o, id_valid_o, id_pc_o, id_class_o, id_rd_o, id_rs1_o,
           id_rs2_o, id_funct3_o, id_funct7b5_o, id_imm_o, id_illegal_o
  );
endinterface

`default_nettype wire

// File: rtl/decode.sv
// ============================================================================
// decode : RV32I decode stage, registered output, optional skid (DECODE_SKID_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module decode #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        dec_start_i,
  input  wire logic [31:0] dec_start_addr_i,
  input  wire logic        dec_flush_i,
  input  wire logic [31:0] dec_flush_addr_i,
  decode_if.slave          bus
);

  localparam logic [3:0] CLS_OP     = 4'd0;
  localparam logic [3:0] CLS_OPIMM  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_FENCE  = 4'd9;
  localparam logic [3:0] CLS_SYSTEM = 4'd10;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic        ill;
  } bundle_t;

  logic [31:0] pc_ff;
  logic        out_valid;
  bundle_t     out_q;
  bundle_t     dec_b;
  logic        accept;
  logic        fetch_ready;

  logic [31:0] instr;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;
  logic [3:0]  cls;
  logic [31:0] imm;

  assign instr = bus.fetch_instr_i;
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Full 7-bit opcode match also rejects any encoding with instr[1:0] != 2'b11
  always_comb begin
    cls     = CLS_ILL;
    imm     = 32'h0;
    illegal = 1'b0;
    case (instr[6:0])
      7'h33: begin
        cls     = CLS_OP;
        illegal = !((f7 == 7'h00) || ((f7 == 7'h20) &&
                    ((instr[14:12] == 3'd0) || (instr[14:12] == 3'd5))));
      end
      7'h13: begin
        cls = CLS_OPIMM;
        imm = imm_i;
        if (instr[14:12] == 3'd1) illegal = (f7 != 7'h00);
        if (instr[14:12] == 3'd5) illegal = !((f7 == 7'h00) || (f7 == 7'h20));
      end
      7'h03: begin
        cls     = CLS_LOAD;
        imm     = imm_i;
        illegal = (instr[14:12] == 3'd3) || (instr[14:12] == 3'd6) || (instr[14:12] == 3'd7);
      end
      7'h23: begin
        cls     = CLS_STORE;
        imm     = imm_s;
        illegal = (instr[14:12] > 3'd2);
      end
      7'h63: begin
        cls     = CLS_BRANCH;
        imm     = imm_b;
        illegal = (instr[14:12] == 3'd2) || (instr[14:12] == 3'd3);
      end
      7'h6F: begin cls = CLS_JAL;    imm = imm_j; end
      7'h67: begin
        cls     = CLS_JALR;
        imm     = imm_i;
        illegal = (instr[14:12] != 3'd0);
      end
      7'h37: begin cls = CLS_LUI;    imm = imm_u; end
      7'h17: begin cls = CLS_AUIPC;  imm = imm_u; end
      7'h0F: begin cls = CLS_FENCE;  imm = imm_i; end
      7'h73: begin cls = CLS_SYSTEM; imm = imm_i; end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      cls = CLS_ILL;
      imm = 32'h0;
    end
  end

  always_comb begin
    dec_b      = '0;
    dec_b.pc   = pc_ff;
    dec_b.cls  = cls;
    dec_b.rd   = ((cls == CLS_STORE) || (cls == CLS_BRANCH)) ? 5'd0 : instr[11:7];
    dec_b.rs1  = instr[19:15];
    dec_b.rs2  = instr[24:20];
    dec_b.f3   = instr[14:12];
    dec_b.f7b5 = instr[30];
    dec_b.imm  = imm;
    dec_b.ill  = illegal;
  end

`ifdef DECODE_SKID_EN
  logic    skid_full;
  bundle_t skid_q;

  // Ready depends only on registered state plus the redirect pulses
  assign fetch_ready = ~skid_full & ~dec_flush_i & ~dec_start_i & ~rst;
`else
  assign fetch_ready = (~out_valid | bus.id_ready_i) & ~dec_flush_i & ~dec_start_i & ~rst;
`endif

  assign accept = bus.fetch_valid_i & fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_ff     <= RESET_PC;
      out_valid <= 1'b0;
      out_q     <= '0;
`ifdef DECODE_SKID_EN
      skid_full <= 1'b0;
      skid_q    <= '0;
`endif
    end else if (dec_flush_i) begin
      pc_ff     <= dec_flush_addr_i & ~32'h3;
      out_valid <= 1'b0;
`ifdef DECODE_SKID_EN
      skid_full <= 1'b0;
`endif
    end else if (dec_start_i) begin
      pc_ff     <= dec_start_addr_i;
      out_valid <= 1'b0;
`ifdef DECODE_SKID_EN
      skid_full <= 1'b0;
`endif
    end else begin
      if (accept) pc_ff <= pc_ff + 32'd4;
`ifdef DECODE_SKID_EN
      if (skid_full) begin
        if (bus.id_ready_i) begin
          out_q     <= skid_q;
          skid_full <= 1'b0;
        end
      end else if (accept) begin
        if (!out_valid || bus.id_ready_i) begin
          out_q     <= dec_b;
          out_valid <= 1'b1;
        end else begin
          skid_q    <= dec_b;
          skid_full <= 1'b1;
        end
      end else if (bus.id_ready_i) begin
        out_valid <= 1'b0;
      end
`else
      if (accept) begin
        out_q     <= dec_b;
        out_valid <= 1'b1;
      end else if (bus.id_ready_i) begin
        out_valid <= 1'b0;
      end
`endif
    end
  end

  assign bus.fetch_ready_o = fetch_ready;
  assign bus.id_valid_o    = out_valid;
  assign bus.id_pc_o       = out_q.pc;
  assign bus.id_class_o    = out_q.cls;
  assign bus.id_rd_o       = out_q.rd;
  assign bus.id_rs1_o      = out_q.rs1;
  assign bus.id_rs2_o      = out_q.rs2;
  assign bus.id_funct3_o   = out_q.f3;
  assign bus.id_funct7b5_o = out_q.f7b5;
  assign bus.id_imm_o      = out_q.imm;
  assign bus.id_illegal_o  = out_q.ill;

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// ============================================================================
// tb_decode : directed bench for decode, queue-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode;
  localparam logic [31:0] RESET_PC = 32'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, flush = 1'b0;
  logic [31:0] start_addr = '0, flush_addr = '0;
  int          total = 0, bad = 0;

  decode_if bus ();

  decode #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .dec_start_i      (start),
    .dec_start_addr_i (start_addr),
    .dec_flush_i      (flush),
    .dec_flush_addr_i (flush_addr),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode built from immediates assembled arithmetically
  function automatic exp_t mdec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  f7 = ins[31:25];
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] sx = {32{ins[31]}};
    logic [31:0] ii = (sx << 12) | 32'(ins[31:20]);
    logic [31:0] ss = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
    logic [31:0] bb = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    logic [31:0] jj = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    logic [31:0] uu = ins & 32'hFFFFF000;
    logic        ill = 1'b0;
    int          c = 15;
    logic [31:0] im = 0;
    case (ins[6:0])
      7'h33: begin c = 0;  ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
      7'h13: begin c = 1;  im = ii;
                   if (f3 == 1) ill = (f7 != 0);
                   if (f3 == 5) ill = !(f7 == 0 || f7 == 7'h20); end
      7'h03: begin c = 2;  im = ii; ill = (f3 == 3 || f3 == 6 || f3 == 7); end
      7'h23: begin c = 3;  im = ss; ill = (f3 > 2); end
      7'h63: begin c = 4;  im = bb; ill = (f3 == 2 || f3 == 3); end
      7'h6F: begin c = 5;  im = jj; end
      7'h67: begin c = 6;  im = ii; ill = (f3 != 0); end
      7'h37: begin c = 7;  im = uu; end
      7'h17: begin c = 8;  im = uu; end
      7'h0F: begin c = 9;  im = ii; end
      7'h73: begin c = 10; im = ii; end
      default: ill = 1'b1;
    endcase
    if (ill) begin c = 15; im = 0; end
    e.pc   = pc;
    e.cls  = 4'(c);
    e.rd   = (c == 3 || c == 4) ? 5'd0 : ins[11:7];
    e.rs1  = ins[19:15];
    e.rs2  = ins[24:20];
    e.f3   = f3;
    e.f7b5 = ins[30];
    e.imm  = im;
    e.ill  = ill;
    return e;
  endfunction

  exp_t        q[$];
  logic [31:0] mpc = RESET_PC;

  // Compare current outputs to the model, then advance the model by one edge
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic rdy_m, acc;
`ifdef DECODE_SKID_EN
        rdy_m = !rst && !flush && !start && (q.size() < 2);
`else
        rdy_m = !rst && !flush && !start && (q.size() == 0 || bus.id_ready_i);
`endif
        chk("valid", 32'(bus.id_valid_o), 32'(q.size() != 0));
        chk("fetch_ready", 32'(bus.fetch_ready_o), 32'(rdy_m));
        if (q.size() != 0) begin
          chk("pc",   bus.id_pc_o, q[0].pc);
          chk("cls",  32'(bus.id_class_o), 32'(q[0].cls));
          chk("rd",   32'(bus.id_rd_o), 32'(q[0].rd));
          chk("rs1",  32'(bus.id_rs1_o), 32'(q[0].rs1));
          chk("rs2",  32'(bus.id_rs2_o), 32'(q[0].rs2));
          chk("f3",   32'(bus.id_funct3_o), 32'(q[0].f3));
          chk("f7b5", 32'(bus.id_funct7b5_o), 32'(q[0].f7b5));
          chk("imm",  bus.id_imm_o, q[0].imm);
          chk("ill",  32'(bus.id_illegal_o), 32'(q[0].ill));
        end
        acc = bus.fetch_valid_i && rdy_m;
        if (rst) begin
          q.delete(); mpc = RESET_PC;
        end else if (flush) begin
          q.delete(); mpc = flush_addr & ~32'h3;
        end else if (start) begin
          q.delete(); mpc = start_addr;
        end else begin
          if (q.size() != 0 && bus.id_ready_i) void'(q.pop_front());
          if (acc) begin
            q.push_back(mdec(bus.fetch_instr_i, mpc));
            mpc = mpc + 32'd4;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec [13] = '{32'h00000000, 32'h40001033, 32'h00002067, 32'h40000033,
                            32'h4000D093, 32'h0000B003, 32'h00112223, 32'h00002063,
                            32'hFE000EE3, 32'h0000100F, 32'h00000073, 32'h00000097,
                            32'h0200D093};

  initial begin
    int n;
    bus.fetch_valid_i = 1'b0;
    bus.fetch_instr_i = '0;
    bus.id_ready_i    = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.id_valid_o), 32'd0);
    chk("rst_pc", bus.id_pc_o, 32'd0);
    chk("rst_imm", bus.id_imm_o, 32'd0);

    // 1) start + addi
    start = 1'b1; start_addr = 32'h100; step(); start = 1'b0;
    bus.fetch_valid_i = 1'b1; bus.fetch_instr_i = 32'h00500093; step();
    bus.fetch_valid_i = 1'b0;
    chk("t1_pc", bus.id_pc_o, 32'h100);
    chk("t1_cls", 32'(bus.id_class_o), 32'd1);
    chk("t1_rd", 32'(bus.id_rd_o), 32'd1);
    chk("t1_imm", bus.id_imm_o, 32'd5);

    // 2) back-to-back jal / lw after a fresh start
    start = 1'b1; step(); start = 1'b0;
    bus.fetch_valid_i = 1'b1; bus.fetch_instr_i = 32'hFFDFF06F; step();
    chk("t2_jal_pc", bus.id_pc_o, 32'h100);
    chk("t2_jal_cls", 32'(bus.id_class_o), 32'd5);
    chk("t2_jal_imm", bus.id_imm_o, 32'hFFFFFFFC);
    bus.fetch_instr_i = 32'h00C12083; step();
    bus.fetch_valid_i = 1'b0;
    chk("t2_lw_pc", bus.id_pc_o, 32'h104);
    chk("t2_lw_imm", bus.id_imm_o, 32'd12);
    step();

    // 3) five-cycle stall with fetch pushing
    bus.id_ready_i = 1'b0; bus.fetch_valid_i = 1'b1; n = 0;
    for (int i = 0; i < 5; i++) begin
      bus.fetch_instr_i = 32'h00100093 + (32'(i) << 20);
      #1;
      if (bus.fetch_valid_i && bus.fetch_ready_o) n++;
      step();
    end
`ifdef DECODE_SKID_EN
    chk("t3_accepts", 32'(n), 32'd2);
`else
    chk("t3_accepts", 32'(n), 32'd1);
`endif
    chk("t3_ready_low", 32'(bus.fetch_ready_o), 32'd0);
    chk("t3_held_pc", bus.id_pc_o, 32'h108);
    chk("t3_held_imm", bus.id_imm_o, 32'd1);

    // 4) flush while held
    flush = 1'b1; flush_addr = 32'h2003; step(); flush = 1'b0;
    chk("t4_valid", 32'(bus.id_valid_o), 32'd0);
    bus.id_ready_i = 1'b1; bus.fetch_instr_i = 32'h123450B7; step();
    bus.fetch_valid_i = 1'b0;
    chk("t4_pc", bus.id_pc_o, 32'h2000);
    chk("t4_cls", 32'(bus.id_class_o), 32'd7);
    chk("t4_imm", bus.id_imm_o, 32'h12345000);

    // 5) illegal encodings then a mixed stream with intermittent stalls
    bus.fetch_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_instr_i = vec[i]; step();
      chk("t5_ill", 32'(bus.id_illegal_o), 32'd1);
      chk("t5_cls", 32'(bus.id_class_o), 32'd15);
    end
    for (int i = 3; i < 13; i++) begin
      bus.fetch_instr_i = vec[i];
      bus.id_ready_i = (i % 3 != 1);
      step();
      while (!bus.fetch_ready_o && i < 13) begin
        bus.id_ready_i = 1'b1; step();
      end
    end
    bus.fetch_valid_i = 1'b0; bus.id_ready_i = 1'b1;
    repeat (3) step();

    // 6) PC wrap, then reset mid-stall
    flush = 1'b1; flush_addr = 32'hFFFFFFFC; step(); flush = 1'b0;
    bus.fetch_valid_i = 1'b1; bus.fetch_instr_i = 32'h00500093; step(); step();
    bus.fetch_valid_i = 1'b0;
    chk("t6_wrap_pc", bus.id_pc_o, 32'h0);
    bus.id_ready_i = 1'b0; bus.fetch_valid_i = 1'b1; repeat (3) step();
    rst = 1'b1; step(); rst = 1'b0; bus.fetch_valid_i = 1'b0;
    chk("t6_rst_valid", 32'(bus.id_valid_o), 32'd0);
    chk("t6_rst_cls", 32'(bus.id_class_o), 32'd0);
    bus.id_ready_i = 1'b1; bus.fetch_valid_i = 1'b1; step();
    bus.fetch_valid_i = 1'b0;
    chk("t6_rst_pc", bus.id_pc_o, RESET_PC);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
